// File: rtl/lupa_cfg_sequencer_pkg.sv
// Shared constants, state encoding and the power-on register image
// for the LUPA configuration sequencer.
package lupa_cfg_pkg;

    localparam int AW          = 4;
    localparam int DW          = 12;
    localparam int NREG        = 16;
    localparam int GAP_CYC_DEF = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_GAP
    } seq_state_e;

    function automatic logic [DW-1:0] img_default(input logic [AW-1:0] a);
        case (a)
            4'd3:    return 12'h0A0;
            4'd4:    return 12'h002;
            4'd7:    return 12'h1E1;
            4'd8:    return 12'h04A;
            4'd9:    return 12'h06B;
            4'd10:   return 12'h055;
            4'd11:   return 12'h0F0;
            4'd12:   return 12'hFB0;
            4'd13:   return 12'hADF;
            4'd14:   return 12'h6DB;
            4'd15:   return 12'h0DB;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lupa_cfg_sequencer_if.sv
// Word handshake between the sequencer and the SPI serializer.
// The sequencer is the master; the serializer acks each finished word.
interface lupa_cfg_sequencer_if;
    import lupa_cfg_pkg::*;

    logic          spi_req;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_dat;
    logic          spi_ack;

    modport master (
        output spi_req,
        output spi_addr,
        output spi_dat,
        input  spi_ack
    );

    modport slave (
        input  spi_req,
        input  spi_addr,
        input  spi_dat,
        output spi_ack
    );

endinterface

// File: rtl/lupa_cfg_sequencer_regfile.sv
// Sensor register image: reset-default load, host write port,
// registered host read port and a combinational sequencer read port.
module lupa_cfg_regfile
    import lupa_cfg_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    input  logic [AW-1:0] seq_addr_i,
    output logic [DW-1:0] seq_data_o
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] rdata_q;

    // Image storage: defaults on reset, host write otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= img_default(AW'(i));
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Host read port; sees the pre-write value on a same-cycle write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o    = rdata_q;
    assign seq_data_o = mem_q[seq_addr_i];

endmodule

// File: rtl/lupa_cfg_sequencer.sv
// Streams a contiguous range of the register image into the SPI
// word writer, one word per req/ack handshake, with status to the host.
module lupa_cfg_sequencer
    import lupa_cfg_pkg::*;
#(
    parameter int unsigned GAP_CYC = GAP_CYC_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clock_40,
    input  logic                 rst_n,
    input  logic                 host_we,
    input  logic [AW-1:0]        host_addr,
    input  logic [DW-1:0]        host_wdata,
    output logic [DW-1:0]        host_rdata,
    input  logic                 cfg_go,
    input  logic [AW-1:0]        cfg_first,
    input  logic [AW-1:0]        cfg_last,
    input  logic                 cfg_abort,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    lupa_cfg_sequencer_if.master spi
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] end_q, end_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] seq_data;
    logic          range_ok;
    logic          last_word;
    logic          abort_now;

    lupa_cfg_regfile u_regfile (
        .clk_i      (clock_40),
        .rst_ni     (rst_n),
        .we_i       (host_we),
        .addr_i     (host_addr),
        .wdata_i    (host_wdata),
        .rdata_o    (host_rdata),
        .seq_addr_i (ptr_q),
        .seq_data_o (seq_data)
    );

    assign range_ok  = (cfg_first <= cfg_last);
    assign last_word = (ptr_q == end_q);
    assign abort_now = cfg_abort && (state_q != S_IDLE);

    // State register
    always_ff @(posedge clock_40) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything while busy
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cfg_go && range_ok) state_d = S_LOAD;
            S_LOAD: state_d = S_REQ;
            S_REQ: begin
                if (spi.spi_ack) begin
                    if (last_word)         state_d = S_IDLE;
                    else if (GAP_CYC == 0) state_d = S_LOAD;
                    else                   state_d = S_GAP;
                end else if (timer_q == TMO) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: if (gap_q == GAP_LAST) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
        if (abort_now) state_d = S_IDLE;
    end

    // Datapath next values: pointer, timers, word snapshot, status
    always_comb begin
        ptr_d   = ptr_q;
        end_d   = end_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_go && range_ok) begin
                    ptr_d  = cfg_first;
                    end_d  = cfg_last;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else if (cfg_go) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                addr_d  = ptr_q;
                dat_d   = seq_data;
                timer_d = '0;
            end
            S_REQ: begin
                timer_d = timer_q + 1'b1;
                if (spi.spi_ack) begin
                    gap_d = '0;
                    if (last_word) done_d = 1'b1;
                    else           ptr_d  = ptr_q + 1'b1;
                end else if (timer_q == TMO) begin
                    err_d = 1'b1;
                end
            end
            S_GAP: gap_d = gap_q + 1'b1;
            default: ;
        endcase
        if (abort_now) begin
            done_d = done_q;
            err_d  = err_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clock_40) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            end_q   <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy         = (state_q != S_IDLE);
        spi.spi_req  = (state_q == S_REQ);
        spi.spi_addr = addr_q;
        spi.spi_dat  = dat_q;
        cfg_done     = done_q;
        cfg_err      = err_q;
    end

endmodule

// File: tb/tb_lupa_cfg_sequencer.sv
// Self-checking bench: randomized ranges, ack delays and host writes
// checked against a word-list model of the register image.
module tb_lupa_cfg_sequencer;
    import lupa_cfg_pkg::*;

    localparam int GAP = 8;
    localparam int TMO = 255;
    localparam logic [11:0] DEF [16] = '{
        12'h000, 12'h000, 12'h000, 12'h0A0, 12'h002, 12'h000, 12'h000, 12'h1E1,
        12'h04A, 12'h06B, 12'h055, 12'h0F0, 12'hFB0, 12'hADF, 12'h6DB, 12'h0DB
    };

    logic          clock_40 = 1'b0;
    logic          rst_n;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          cfg_go;
    logic [AW-1:0] cfg_first;
    logic [AW-1:0] cfg_last;
    logic          cfg_abort;
    logic          busy;
    logic          cfg_done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] img [16];

    lupa_cfg_sequencer_if spi_if ();

    lupa_cfg_sequencer #(
        .GAP_CYC (GAP),
        .TIMEOUT (TMO)
    ) dut (
        .clock_40   (clock_40),
        .rst_n      (rst_n),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .cfg_go     (cfg_go),
        .cfg_first  (cfg_first),
        .cfg_last   (cfg_last),
        .cfg_abort  (cfg_abort),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .spi        (spi_if.master)
    );

    always #5 clock_40 = ~clock_40;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) img[i] = DEF[i];
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] v);
        host_we = 1'b1; host_addr = AW'(a); host_wdata = v;
        img[a] = v;
        @(negedge clock_40);
        host_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_we = 0; host_addr = '0; host_wdata = '0;
        cfg_go = 0; cfg_first = '0; cfg_last = '0; cfg_abort = 0;
        spi_if.spi_ack = 1'b0;
        repeat (3) @(negedge clock_40);
        checks++;
        if ({busy, spi_if.spi_req, cfg_done, cfg_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, spi_if.spi_req, cfg_done, cfg_err});
        end
        checks++;
        if ({host_rdata, spi_if.spi_addr, spi_if.spi_dat} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h dat %h expected 0",
                     host_rdata, spi_if.spi_addr, spi_if.spi_dat);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_host_read();
        int a;
        logic [DW-1:0] v;
        logic w;
        host_addr = 4'd12;
        @(negedge clock_40);
        checks++;
        if (host_rdata !== 12'hFB0) begin
            errors++; $display("FAIL read12: got %h expected fb0", host_rdata);
        end
        host_addr = 4'd13;
        @(negedge clock_40);
        checks++;
        if (host_rdata !== 12'hADF) begin
            errors++; $display("FAIL read13: got %h expected adf", host_rdata);
        end
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(0, 15);
            v = DW'($urandom);
            w = 1'($urandom_range(0, 1));
            host_we = w; host_addr = AW'(a); host_wdata = v;
            @(negedge clock_40);
            checks++;
            if (host_rdata !== img[a]) begin
                errors++;
                $display("FAIL read_rbw a=%0d: got %h expected %h", a, host_rdata, img[a]);
            end
            if (w) img[a] = v;
            host_we = 1'b0;
            @(negedge clock_40);
            checks++;
            if (host_rdata !== img[a]) begin
                errors++;
                $display("FAIL read_after a=%0d: got %h expected %h", a, host_rdata, img[a]);
            end
        end
    endtask

    task automatic run_seq(input int first, input int last, input int dmin,
                           input int dmax, input bit rnd_wr);
        int cnt, d, a, expect_lat;
        logic [DW-1:0] exp_dat;
        cfg_first = AW'(first); cfg_last = AW'(last); cfg_go = 1'b1;
        expect_lat = 2;
        for (int w = first; w <= last; w++) begin
            cnt = 0;
            do begin
                @(negedge clock_40);
                cnt++;
                cfg_go = 0; spi_if.spi_ack = 0; host_we = 0;
                if (rnd_wr && cnt == 1 && w != first && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 15);
                    host_we = 1; host_addr = AW'(a); host_wdata = DW'($urandom);
                    img[a] = host_wdata;
                end
            end while (!spi_if.spi_req && cnt < 64);
            checks++;
            if (cnt !== expect_lat || spi_if.spi_req !== 1'b1) begin
                errors++;
                $display("FAIL req_latency w=%0d: got %0d cycles expected %0d", w, cnt, expect_lat);
                if (!spi_if.spi_req) return;
            end
            exp_dat = img[w];
            checks++;
            if (spi_if.spi_addr !== AW'(w) || spi_if.spi_dat !== exp_dat || busy !== 1'b1) begin
                errors++;
                $display("FAIL word w=%0d: got addr %0d dat %h busy %b expected %0d %h 1",
                         w, spi_if.spi_addr, spi_if.spi_dat, busy, w, exp_dat);
            end
            if (rnd_wr && $urandom_range(0, 2) == 0) begin
                host_we = 1; host_addr = AW'(w); host_wdata = DW'($urandom);
                img[w] = host_wdata;
            end
            d = $urandom_range(dmin, dmax);
            repeat (d) begin
                @(negedge clock_40);
                host_we = 0;
                checks++;
                if (spi_if.spi_req !== 1'b1 || spi_if.spi_dat !== exp_dat) begin
                    errors++;
                    $display("FAIL req_hold w=%0d: got req %b dat %h expected 1 %h",
                             w, spi_if.spi_req, spi_if.spi_dat, exp_dat);
                end
            end
            spi_if.spi_ack = 1'b1;
            expect_lat = GAP + 2;
        end
        @(negedge clock_40);
        spi_if.spi_ack = 0; host_we = 0;
        checks++;
        if ({spi_if.spi_req, busy, cfg_done, cfg_err} !== 4'b0010) begin
            errors++;
            $display("FAIL seq_end: got req,busy,done,err %b expected 0010",
                     {spi_if.spi_req, busy, cfg_done, cfg_err});
        end
    endtask

    task automatic test_seq_basic();
        host_write(5, 12'h123);
        run_seq(3, 5, 4, 4, 1'b0);
    endtask

    task automatic test_full_range();
        run_seq(0, 15, 0, 0, 1'b0);
    endtask

    task automatic test_bad_range();
        bit seen = 0;
        cfg_first = 4'd9; cfg_last = 4'd2; cfg_go = 1'b1;
        @(negedge clock_40);
        cfg_go = 1'b0;
        checks++;
        if ({cfg_err, busy, cfg_done} !== 3'b101) begin
            errors++;
            $display("FAIL bad_range: got err,busy,done %b expected 101", {cfg_err, busy, cfg_done});
        end
        spi_if.spi_ack = 1'b1;
        repeat (6) begin
            @(negedge clock_40);
            spi_if.spi_ack = 1'b0;
            if (spi_if.spi_req || busy) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL bad_range_idle: got activity %b expected 0", seen);
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        int hc = 0;
        cfg_first = 4'd0; cfg_last = 4'd0; cfg_go = 1'b1;
        do begin
            @(negedge clock_40); cfg_go = 0; cnt++;
        end while (!spi_if.spi_req && cnt < 64);
        checks++;
        if (cnt !== 2) begin
            errors++; $display("FAIL tmo_latency: got %0d expected 2", cnt);
        end
        while (spi_if.spi_req && hc < 400) begin
            @(negedge clock_40); hc++;
        end
        checks++;
        if (hc !== TMO + 1) begin
            errors++; $display("FAIL tmo_hold: got %0d cycles expected %0d", hc, TMO + 1);
        end
        checks++;
        if ({cfg_err, cfg_done, busy} !== 3'b100) begin
            errors++;
            $display("FAIL tmo_status: got err,done,busy %b expected 100", {cfg_err, cfg_done, busy});
        end
    endtask

    task automatic test_random();
        int f, l;
        for (int i = 0; i < 6; i++) begin
            f = $urandom_range(0, 15);
            l = $urandom_range(f, 15);
            run_seq(f, l, 0, 6, 1'b1);
        end
    endtask

    task automatic test_abort();
        int cnt;
        cfg_first = 4'd2; cfg_last = 4'd6; cfg_go = 1'b1;
        @(negedge clock_40); cfg_go = 0;
        @(negedge clock_40);
        checks++;
        if (spi_if.spi_req !== 1'b1 || spi_if.spi_addr !== 4'd2) begin
            errors++;
            $display("FAIL abort_w0: got req %b addr %0d expected 1 2", spi_if.spi_req, spi_if.spi_addr);
        end
        repeat (2) @(negedge clock_40);
        spi_if.spi_ack = 1'b1;
        cnt = 0;
        do begin
            @(negedge clock_40); cnt++;
            spi_if.spi_ack = 0; cfg_go = 0;
            if (cnt == 3) begin
                cfg_go = 1; cfg_first = 4'd0; cfg_last = 4'd0;
            end
        end while (!spi_if.spi_req && cnt < 64);
        checks++;
        if (cnt !== GAP + 2 || spi_if.spi_addr !== 4'd3 || spi_if.spi_dat !== img[3]) begin
            errors++;
            $display("FAIL go_busy: got lat %0d addr %0d dat %h expected %0d 3 %h",
                     cnt, spi_if.spi_addr, spi_if.spi_dat, GAP + 2, img[3]);
        end
        repeat (2) @(negedge clock_40);
        spi_if.spi_ack = 1; cfg_abort = 1; cfg_go = 1;
        cfg_first = 4'd0; cfg_last = 4'd15;
        @(negedge clock_40);
        spi_if.spi_ack = 0; cfg_abort = 0; cfg_go = 0;
        checks++;
        if ({spi_if.spi_req, busy, cfg_done, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL abort: got req,busy,done,err %b expected 0000",
                     {spi_if.spi_req, busy, cfg_done, cfg_err});
        end
        repeat (4) @(negedge clock_40);
        checks++;
        if (busy !== 1'b0 || spi_if.spi_req !== 1'b0) begin
            errors++; $display("FAIL abort_stay: got busy %b req %b expected 0 0", busy, spi_if.spi_req);
        end
        host_write(7, 12'h555);
        cfg_first = 4'd7; cfg_last = 4'd9; cfg_go = 1'b1;
        @(negedge clock_40); cfg_go = 0;
        @(negedge clock_40);
        checks++;
        if (spi_if.spi_req !== 1'b1 || spi_if.spi_dat !== 12'h555) begin
            errors++;
            $display("FAIL rst_w0: got req %b dat %h expected 1 555", spi_if.spi_req, spi_if.spi_dat);
        end
        rst_n = 1'b0;
        @(negedge clock_40);
        checks++;
        if ({spi_if.spi_req, busy} !== 2'b00 || spi_if.spi_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid: got req %b busy %b addr %0d expected 0 0 0",
                     spi_if.spi_req, busy, spi_if.spi_addr);
        end
        rst_n = 1'b1;
        model_reset();
        host_addr = 4'd7;
        @(negedge clock_40);
        checks++;
        if (host_rdata !== img[7] || {cfg_done, cfg_err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_image: got %h done %b err %b expected %h 0 0",
                     host_rdata, cfg_done, cfg_err, img[7]);
        end
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_seq_basic();
        test_full_range();
        test_bad_range();
        test_timeout();
        test_random();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
